// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu shared definitions: funct3 codes, FSM states and
// access-geometry helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

    localparam int REG_SIZE = 31;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Access size in bytes; illegal codes are rejected before use.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic is_store,
                                      input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // True when the access spills past the end of its word.
    function automatic logic f3_cross(input logic [1:0] off,
                                      input logic [2:0] size);
        return ({2'b00, off} + {1'b0, size}) > 4'd4;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Byte-lane steering for one word access of a possibly split
// request: store mask/data and load byte extraction per phase.
module lsu_lane_align (
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        phase,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata_sh,
    output logic [31:0] rbytes,
    output logic [3:0]  rmask
);

    logic [3:0]  acc;
    logic [3:0]  lo_fit;
    logic [7:0]  lane8;
    logic [63:0] w64;
    logic [63:0] r64;
    logic [31:0] wraw;

    // Place access bytes on an 8-lane (two word) window, then pick the half.
    always_comb begin
        acc      = 4'((5'd1 << size) - 5'd1);
        lo_fit   = 4'hF >> off;
        lane8    = {4'b0000, acc} << off;
        we       = phase ? lane8[7:4] : lane8[3:0];
        w64      = {32'h0, wdata} << {off, 3'b000};
        wraw     = phase ? w64[63:32] : w64[31:0];
        wdata_sh = '0;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                wdata_sh[8*i +: 8] = wraw[8*i +: 8];
            end
        end
        r64    = phase ? {rdata, 32'h0} : {32'h0, rdata};
        r64    = r64 >> {off, 3'b000};
        rbytes = r64[31:0];
        rmask  = phase ? (acc & ~lo_fit) : (acc & lo_fit);
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one request at a time, word-crossing
// accesses split into two word cycles, extended load response.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter bit MISALIGNED_EN = 1'b1,
    parameter int XLEN          = REG_SIZE + 1
) (
    input  logic            clock_mem,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] addr_to_dmem,
    input  logic [XLEN-1:0] load_data_from_dmem,
    output logic [XLEN-1:0] store_data_to_dmem,
    output logic [3:0]      store_we_to_dmem
);

    lsu_state_t      state_q;
    logic            is_store_q;
    logic            err_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [31:0]     buf_q;

    logic [2:0]      size_q;
    logic            cross_q;
    logic            phase;
    logic            active;
    logic            req_err;
    logic [XLEN-1:0] base;
    logic [3:0]      al_we;
    logic [3:0]      al_rmask;
    logic [31:0]     al_wdata;
    logic [31:0]     al_rbytes;
    logic [31:0]     ext;

    assign size_q  = f3_size(f3_q);
    assign cross_q = f3_cross(addr_q[1:0], size_q);
    assign phase   = (state_q == ACC_HI);
    assign active  = ((state_q == ACC_LO) || phase) && !err_q;
    assign base    = {addr_q[XLEN-1:2], 2'b00};
    assign req_err = !f3_legal(req_is_store, req_funct3) ||
                     (!MISALIGNED_EN &&
                      f3_cross(req_addr[1:0], f3_size(req_funct3)));

    lsu_lane_align u_align (
        .off      (addr_q[1:0]),
        .size     (size_q),
        .phase    (phase),
        .wdata    (wdata_q[31:0]),
        .rdata    (load_data_from_dmem[31:0]),
        .we       (al_we),
        .wdata_sh (al_wdata),
        .rbytes   (al_rbytes),
        .rmask    (al_rmask)
    );

    // Request latch, load byte buffer and sequencing FSM.
    always_ff @(posedge clock_mem) begin
        if (rst) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        f3_q       <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        err_q      <= req_err;
                        buf_q      <= '0;
                        state_q    <= ACC_LO;
                    end
                end
                ACC_LO, ACC_HI: begin
                    if (active && !is_store_q) begin
                        for (int i = 0; i < 4; i++) begin
                            if (al_rmask[i]) begin
                                buf_q[8*i +: 8] <= al_rbytes[8*i +: 8];
                            end
                        end
                    end
                    if (!phase && !err_q && cross_q) begin
                        state_q <= ACC_HI;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sign/zero extension of the assembled load bytes.
    always_comb begin
        ext = buf_q;
        case (f3_q)
            F3_B:    ext = {{24{buf_q[7]}}, buf_q[7:0]};
            F3_H:    ext = {{16{buf_q[15]}}, buf_q[15:0]};
            F3_BU:   ext = {24'h0, buf_q[7:0]};
            F3_HU:   ext = {16'h0, buf_q[15:0]};
            default: ext = buf_q;
        endcase
    end

    assign req_ready          = (state_q == IDLE);
    assign addr_to_dmem       = active ? (phase ? base + XLEN'(4) : base) : '0;
    assign store_we_to_dmem   = (active && is_store_q && !rst) ? al_we : 4'b0000;
    assign store_data_to_dmem = (active && is_store_q) ? XLEN'(al_wdata) : '0;
    assign resp_valid         = (state_q == RESP);
    assign resp_err           = resp_valid && err_q;
    assign resp_rdata         = (resp_valid && !err_q && !is_store_q) ?
                                XLEN'(ext) : '0;

endmodule
